// File: rtl/leb128_decoder.sv
// Byte-serial LEB128 decoder: one byte per cycle in, 64-bit value + length + malformed flag out.
// Latency 1 cycle after the terminating byte; result held until out_ready, input stalled meanwhile.
module leb128_decoder #(
    parameter int MAX_BYTES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        is_signed,
    input  logic        is_64,
    output logic [63:0] out_value,
    output logic [3:0]  out_len,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [3:0] LIM64 = 4'(MAX_BYTES);
    localparam logic [3:0] LIM32 = 4'((MAX_BYTES < 5) ? MAX_BYTES : 5);

    state_t      state;
    logic [3:0]  count;
    logic        sgn_q;
    logic        w64_q;
    logic [63:0] acc;

    logic        sgn;
    logic        w64;
    logic [3:0]  lim;
    logic        last;
    logic [6:0]  sh;
    logic [63:0] acc_next;
    logic [63:0] ext_mask;
    logic [63:0] value;
    logic        bad_tail;
    logic        err;
    logic        done;

    // Mode comes straight from the inputs on the first byte, from the latch afterwards.
    assign sgn = (count == 4'd0) ? is_signed : sgn_q;
    assign w64 = (count == 4'd0) ? is_64 : w64_q;
    assign lim = w64 ? LIM64 : LIM32;
    assign last = ((count + 4'd1) == lim);

    assign sh       = 7'(count) * 7'd7;
    assign acc_next = acc | ({57'd0, in_byte[6:0]} << sh);
    assign ext_mask = ~64'd0 << (sh + 7'd7);
    assign value    = acc_next | ((sgn && in_byte[6]) ? ext_mask : 64'd0);

    // Final-byte payload must not carry bits beyond the target width.
    always_comb begin
        bad_tail = 1'b0;
        if (w64) begin
            if (sgn)
                bad_tail = (in_byte != 8'h00) && (in_byte != 8'h7F);
            else
                bad_tail = |in_byte[6:1];
        end else begin
            if (sgn)
                bad_tail = (in_byte[6:4] != {3{in_byte[3]}});
            else
                bad_tail = |in_byte[6:4];
        end
    end

    assign err  = last && (in_byte[7] || bad_tail);
    assign done = !in_byte[7] || last;

    assign in_ready = reset && (state == ACCUM);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ACCUM;
            count     <= 4'd0;
            sgn_q     <= 1'b0;
            w64_q     <= 1'b0;
            acc       <= 64'd0;
            out_value <= 64'd0;
            out_len   <= 4'd0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (count == 4'd0) begin
                            sgn_q <= is_signed;
                            w64_q <= is_64;
                        end
                        if (done) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_err   <= err;
                            out_len   <= count + 4'd1;
                            out_value <= err ? 64'd0 : (w64 ? value : {32'd0, value[31:0]});
                            count     <= 4'd0;
                            acc       <= 64'd0;
                        end else begin
                            acc   <= acc_next;
                            count <= count + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_leb128_decoder.sv
// Directed bench for leb128_decoder: hand-computed vectors, immediate-assertion checks.
module tb_leb128_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        is_signed = 1'b0;
    logic        is_64 = 1'b0;
    logic [63:0] out_value;
    logic [3:0]  out_len;
    logic        out_err;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int total = 0;
    int bad = 0;

    leb128_decoder #(.MAX_BYTES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .is_64     (is_64),
        .out_value (out_value),
        .out_len   (out_len),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for one cycle; the decoder must be ready when it is offered.
    task automatic send(input logic [7:0] b, input int gap);
        chk("in_ready_before_byte", 64'(in_ready), 64'd1);
        in_byte  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < gap; i++) tick();
    endtask

    // Result must already be visible one cycle after the last byte, then drained.
    task automatic expect_result(input string tag, input logic [63:0] v,
                                 input logic [3:0] len, input logic e);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_value"}, out_value, v);
        chk({tag, "_len"},   64'(out_len), 64'(len));
        chk({tag, "_err"},   64'(out_err), 64'(e));
        chk({tag, "_in_ready_hold"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_cleared"}, 64'(out_valid), 64'd0);
        chk({tag, "_err_cleared"}, 64'(out_err), 64'd0);
        chk({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_err",   64'(out_err), 64'd0);
        chk("rst_value", out_value, 64'd0);
        chk("rst_len",   64'(out_len), 64'd0);
        reset = 1'b1;
        #1;
        chk("rst_release_in_ready", 64'(in_ready), 64'd1);

        // u32 single byte
        is_signed = 1'b0; is_64 = 1'b0;
        send(8'h03, 0);
        expect_result("u32_03", 64'd3, 4'd1, 1'b0);

        // s32 single byte, negative
        is_signed = 1'b1; is_64 = 1'b0;
        send(8'h7F, 0);
        expect_result("s32_7f", 64'h0000_0000_FFFF_FFFF, 4'd1, 1'b0);

        // u32 three bytes, back-to-back then with 2-cycle gaps
        is_signed = 1'b0; is_64 = 1'b0;
        send(8'hE5, 0); send(8'h8E, 0);
        chk("u32_3b_no_early_valid", 64'(out_valid), 64'd0);
        send(8'h26, 0);
        expect_result("u32_3b", 64'h98765, 4'd3, 1'b0);
        send(8'hE5, 2); send(8'h8E, 2);
        chk("u32_gap_no_early_valid", 64'(out_valid), 64'd0);
        send(8'h26, 0);
        expect_result("u32_gap", 64'h98765, 4'd3, 1'b0);

        // s64 three bytes; mode inputs flip after the first byte and must be ignored
        is_signed = 1'b1; is_64 = 1'b1;
        send(8'hC0, 0);
        is_signed = 1'b0; is_64 = 1'b0;
        send(8'hBB, 0); send(8'h78, 0);
        expect_result("s64_neg", 64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 1'b0);

        // u32 max, 5 bytes
        is_signed = 1'b0; is_64 = 1'b0;
        send(8'hFF, 0); send(8'hFF, 0); send(8'hFF, 0); send(8'hFF, 0); send(8'h0F, 0);
        expect_result("u32_max", 64'h0000_0000_FFFF_FFFF, 4'd5, 1'b0);

        // u32 5th byte with excess payload bits
        send(8'hFF, 0); send(8'hFF, 0); send(8'hFF, 0); send(8'hFF, 0); send(8'h7F, 0);
        expect_result("u32_excess", 64'd0, 4'd5, 1'b1);

        // u32 overlong: continuation on 5th byte stops the decoder
        for (int i = 0; i < 5; i++) send(8'h80, 0);
        chk("u32_overlong_in_ready", 64'(in_ready), 64'd0);
        in_byte = 8'h01; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("u32_overlong_still_holding", 64'(out_len), 64'd5);
        expect_result("u32_overlong", 64'd0, 4'd5, 1'b1);

        // s32 5th byte sign-consistent: 80 80 80 80 78 -> 0x80000000
        is_signed = 1'b1; is_64 = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h80, 0);
        send(8'h78, 0);
        expect_result("s32_min", 64'h0000_0000_8000_0000, 4'd5, 1'b0);

        // s64 10-byte encodings: 7F tail accepted, 7E tail rejected
        is_signed = 1'b1; is_64 = 1'b1;
        for (int i = 0; i < 9; i++) send(8'h80, 0);
        send(8'h7F, 0);
        expect_result("s64_10b_ok", 64'h8000_0000_0000_0000, 4'd10, 1'b0);
        for (int i = 0; i < 9; i++) send(8'h80, 0);
        send(8'h7E, 0);
        expect_result("s64_10b_bad", 64'd0, 4'd10, 1'b1);

        // u64 10th byte with bit 1 set is malformed
        is_signed = 1'b0; is_64 = 1'b1;
        for (int i = 0; i < 9; i++) send(8'h80, 0);
        send(8'h02, 0);
        expect_result("u64_10b_bad", 64'd0, 4'd10, 1'b1);

        // Reset mid-decode discards partial bytes
        is_signed = 1'b0; is_64 = 1'b0;
        send(8'hE5, 0); send(8'h8E, 0);
        reset = 1'b0;
        tick();
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        reset = 1'b1;
        #1;
        send(8'h05, 0);
        expect_result("after_rst", 64'd5, 4'd1, 1'b0);

        // Held result stays stable with out_ready low and input offered
        send(8'h2A, 0);
        in_byte = 8'h11; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_value", out_value, 64'd42);
            chk("hold_len", 64'(out_len), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        expect_result("hold_drain", 64'd42, 4'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
